// File: rtl/cnt_share_ctrl.sv
// cnt_share_ctrl
//   Shares one bounded up-counter between two requesters. Arbitration is
//   round-robin. Each grant runs one count sequence from LO to HI, pulses
//   done, and then releases the counter. If the owner drops its request
//   during the sequence, the run is aborted and aborted pulses instead.
//
//   Optional build macro: CNT_RUN_STATS_EN adds saturating per-requester
//   counters of completed sequences (runs0, runs1).
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   req      [1:0] level request per requester
//   pause    freezes counting while running
//   gnt      [1:0] one-hot grant, zero when not busy
//   owner    index of the granted requester (valid while busy)
//   busy     high while a sequence is running or completing
//   count    [WIDTH-1:0] counter value, LO when idle
//   done     one-cycle pulse on sequence completion
//   aborted  one-cycle pulse when the owner drops req mid-run
//   runs0/1  [7:0] completed-sequence counts (CNT_RUN_STATS_EN only)
//
// state  | meaning
// IDLE   | counter parked at LO, waiting for a request
// RUN    | owner granted, counting LO..HI (pause freezes)
// DONE   | one-cycle completion, count at HI, done high
module cnt_share_ctrl #(
  parameter int WIDTH = 4,
  parameter int LO    = 3,
  parameter int HI    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic             pause,
  output logic [1:0]       gnt,
  output logic             owner,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             aborted
`ifdef CNT_RUN_STATS_EN
  ,
  output logic [7:0]       runs0,
  output logic [7:0]       runs1
`endif
);

  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  logic   last_owner;
  logic   winner;

  // A lone request wins outright; when both requesters ask at once,
  // the one that did not hold the counter last time gets it.
  always_comb begin
    winner = ~last_owner;
    if (req == 2'b01) begin
      winner = 1'b0;
    end else if (req == 2'b10) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= LO_V;
      gnt        <= 2'b00;
      owner      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      last_owner <= 1'b1;
`ifdef CNT_RUN_STATS_EN
      runs0      <= 8'd0;
      runs1      <= 8'd0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          count <= LO_V;
          if (req != 2'b00) begin
            state      <= S_RUN;
            gnt        <= winner ? 2'b10 : 2'b01;
            owner      <= winner;
            busy       <= 1'b1;
            last_owner <= winner;
          end
        end
        S_RUN: begin
          // Losing the owner's request outranks both pause and completion.
          if (!req[owner]) begin
            state   <= S_IDLE;
            count   <= LO_V;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (!pause) begin
            if (count == HI_V) begin
              state <= S_DONE;
              done  <= 1'b1;
`ifdef CNT_RUN_STATS_EN
              if (!owner && runs0 != 8'd255) begin
                runs0 <= runs0 + 8'd1;
              end
              if (owner && runs1 != 8'd255) begin
                runs1 <= runs1 + 8'd1;
              end
`endif
            end else begin
              count <= count + WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          count <= LO_V;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          count <= LO_V;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_share_ctrl.sv
module tb_cnt_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic       pause;
  logic [1:0] gnt;
  logic       owner;
  logic       busy;
  logic [3:0] count;
  logic       done;
  logic       aborted;
`ifdef CNT_RUN_STATS_EN
  logic [7:0] runs0;
  logic [7:0] runs1;
`endif

  cnt_share_ctrl #(.WIDTH(4), .LO(3), .HI(12)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pause   (pause),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .aborted (aborted)
`ifdef CNT_RUN_STATS_EN
    ,
    .runs0   (runs0),
    .runs1   (runs1)
`endif
  );

  always #5 clk = ~clk;

  localparam int K_GNT  = 0;
  localparam int K_DONE = 1;
  localparam int K_ABT  = 2;
  localparam int K_REL  = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [1:0] gnt;
    logic [3:0] count;
  } ev_t;

  ev_t  q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  logic prev_busy;
  int   kind;
  ev_t  e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int k, input int c, input logic [1:0] g, input logic [3:0] n);
    ev_t x;
    x.kind = k; x.cyc = c; x.gnt = g; x.count = n;
    q.push_back(x);
  endtask

  // Monitor: invariants every cycle; pops the scoreboard on each DUT event.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_onehot", {31'b0, $onehot0(gnt)}, 32'd1);
      chk("inv_gnt_busy", {31'b0, (gnt != 2'b00)}, {31'b0, busy});
      chk("inv_done_abt", {31'b0, (done && aborted)}, 32'd0);
      kind = -1;
      if (aborted === 1'b1)                           kind = K_ABT;
      else if (done === 1'b1)                         kind = K_DONE;
      else if (busy === 1'b1 && prev_busy !== 1'b1)   kind = K_GNT;
      else if (busy === 1'b0 && prev_busy === 1'b1)   kind = K_REL;
      if (kind >= 0) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event kind=%0d cyc=%0d gnt=%b count=%0d", kind, cyc, gnt, count);
        end else begin
          e = q.pop_front();
          chk("ev_kind", kind, e.kind);
          chk("ev_cyc", cyc, e.cyc);
          chk("ev_gnt", {30'b0, gnt}, {30'b0, e.gnt});
          chk("ev_count", {28'b0, count}, {28'b0, e.count});
          if (e.gnt != 2'b00) chk("ev_owner", {31'b0, owner}, {31'b0, e.gnt[1]});
        end
      end
    end
    prev_busy = busy;
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset(input bit in_run);
    if (in_run) push(K_REL, cyc + 1, 2'b00, 4'd3);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One uninterrupted sequence: grant, 10 RUN cycles, DONE, release.
  task automatic run_full(input logic [1:0] r, input logic [1:0] eg);
    int g;
    g = cyc + 1;
    req = r;
    push(K_GNT,  g,      eg,    4'd3);
    push(K_DONE, g + 10, eg,    4'd12);
    push(K_REL,  g + 11, 2'b00, 4'd3);
    wait_to(g + 5);
    chk("run_mid_count", {28'b0, count}, 32'd8);
    wait_to(g + 11);
    req = 2'b00;
  endtask

  initial begin
    int g;
    rst   = 1'b1;
    req   = 2'b00;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count",   {28'b0, count}, 32'd3);
    chk("rst_gnt",     {30'b0, gnt},   32'd0);
    chk("rst_owner",   {31'b0, owner}, 32'd0);
    chk("rst_busy",    {31'b0, busy},  32'd0);
    chk("rst_done",    {31'b0, done},  32'd0);
    chk("rst_aborted", {31'b0, aborted}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // single requester, full sequence
    run_full(2'b01, 2'b01);

    // both requesting: 0, then 1, then 0
    do_reset(1'b0);
    run_full(2'b11, 2'b01);
    run_full(2'b11, 2'b10);
    run_full(2'b11, 2'b01);

    // pause for 4 cycles at count 7
    g = cyc + 1;
    req = 2'b01;
    push(K_GNT,  g,      2'b01, 4'd3);
    push(K_DONE, g + 14, 2'b01, 4'd12);
    push(K_REL,  g + 15, 2'b00, 4'd3);
    wait_to(g + 4);
    chk("pause_pre", {28'b0, count}, 32'd7);
    pause = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      wait_to(g + i);
      chk("pause_hold", {28'b0, count}, 32'd7);
    end
    pause = 1'b0;
    wait_to(g + 15);
    req = 2'b00;

    // owner 1 drops req at count 9 while req[0] waits
    g = cyc + 1;
    req = 2'b10;
    push(K_GNT, g, 2'b10, 4'd3);
    wait_to(g + 6);
    chk("abt_pre", {28'b0, count}, 32'd9);
    req = 2'b01;
    push(K_ABT,  g + 7,  2'b00, 4'd3);
    push(K_GNT,  g + 8,  2'b01, 4'd3);
    push(K_DONE, g + 18, 2'b01, 4'd12);
    push(K_REL,  g + 19, 2'b00, 4'd3);
    wait_to(g + 19);
    req = 2'b00;

    // reset mid-run at count 10
    g = cyc + 1;
    req = 2'b01;
    push(K_GNT, g, 2'b01, 4'd3);
    wait_to(g + 7);
    chk("rstrun_pre", {28'b0, count}, 32'd10);
    do_reset(1'b1);
    chk("rstrun_count",   {28'b0, count}, 32'd3);
    chk("rstrun_gnt",     {30'b0, gnt},   32'd0);
    chk("rstrun_busy",    {31'b0, busy},  32'd0);
    chk("rstrun_done",    {31'b0, done},  32'd0);
    chk("rstrun_aborted", {31'b0, aborted}, 32'd0);
`ifdef CNT_RUN_STATS_EN
    chk("rstrun_runs0", {24'b0, runs0}, 32'd0);
    chk("rstrun_runs1", {24'b0, runs1}, 32'd0);

    // three completions and one abort for requester 0
    for (int i = 0; i < 3; i++) run_full(2'b01, 2'b01);
    g = cyc + 1;
    req = 2'b01;
    push(K_GNT, g, 2'b01, 4'd3);
    wait_to(g + 3);
    req = 2'b00;
    push(K_ABT, g + 4, 2'b00, 4'd3);
    wait_to(g + 5);
    chk("stats_runs0", {24'b0, runs0}, 32'd3);
    chk("stats_runs1", {24'b0, runs1}, 32'd0);

    // 260 completions in total saturate at 255
    for (int i = 0; i < 257; i++) run_full(2'b01, 2'b01);
    chk("stats_sat_runs0", {24'b0, runs0}, 32'd255);
    run_full(2'b10, 2'b10);
    chk("stats_runs1_one", {24'b0, runs1}, 32'd1);
    chk("stats_sat_hold",  {24'b0, runs0}, 32'd255);
`endif

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
